// File: rtl/sram_arbiter_pkg.sv
// Shared types for the external-SRAM arbiter: word/address aliases, arbiter
// state encoding and the captured request payload driven onto the mem_* bus.
`timescale 1ns/1ps
package sram_arbiter_pkg;

  localparam int unsigned WORD_W     = 32;
  localparam int unsigned RAM_ADDR_W = 20;
  localparam int unsigned MASK_W     = 4;
  localparam int unsigned STREAK_W   = 4;

  typedef logic                  Bit_t;
  typedef logic [WORD_W-1:0]     Word_t;
  typedef logic [RAM_ADDR_W-1:0] Ram_addr_t;
  typedef logic [MASK_W-1:0]     Mask_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_DM = 2'd1,
    BUSY_IF = 2'd2
  } Arb_state_t;

  // Request as presented to the SRAM controller; held stable while busy.
  typedef struct packed {
    Bit_t      read_op;
    Bit_t      write_op;
    Ram_addr_t addr;
    Word_t     wdata;
    Mask_t     byte_mask;
  } Mem_req_t;

  localparam Mask_t MASK_ALL = '1;

endpackage

// File: rtl/sram_arbiter.sv
// Two-requester arbiter for the single external-SRAM port: DM has priority,
// IF is forced in after MAX_DM_STREAK back-to-back contested DM grants.
`timescale 1ns/1ps
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int unsigned MAX_DM_STREAK = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [19:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_stall,
  input  logic        dm_read,
  input  logic        dm_write,
  input  logic [19:0] dm_addr,
  input  logic [31:0] dm_wdata,
  input  logic [3:0]  dm_byte_mask,
  output logic [31:0] dm_rdata,
  output logic        dm_stall,
  output logic        mem_read_op,
  output logic        mem_write_op,
  output logic [19:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_byte_mask,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DM_STREAK);

  Arb_state_t          state_q, state_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  Mem_req_t            req_q, req_d;
  Word_t               if_rdata_q, if_rdata_d;
  Word_t               dm_rdata_q, dm_rdata_d;

  logic dm_pend;
  logic dm_ack_c;
  logic if_ack_c;
  logic dm_rd_done_c;
  logic if_rd_done_c;

  // Completion qualifiers; a withdrawn request discards its read data.
  assign dm_pend      = dm_read | dm_write;
  assign dm_ack_c     = (state_q == BUSY_DM) & mem_ack;
  assign if_ack_c     = (state_q == BUSY_IF) & mem_ack;
  assign dm_rd_done_c = dm_ack_c & req_q.read_op & dm_read;
  assign if_rd_done_c = if_ack_c & if_req;

  always_comb begin
    state_d    = state_q;
    streak_d   = streak_q;
    req_d      = req_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;

    case (state_q)
      IDLE: begin
        if (dm_pend && (!if_req || (streak_q < STREAK_MAX))) begin
          state_d         = BUSY_DM;
          req_d.write_op  = dm_write;
          req_d.read_op   = dm_read & ~dm_write;
          req_d.addr      = dm_addr;
          req_d.wdata     = dm_wdata;
          req_d.byte_mask = dm_byte_mask;
          if (if_req) begin
            streak_d = (streak_q < STREAK_MAX) ? streak_q + STREAK_W'(1) : streak_q;
          end else begin
            streak_d = '0;
          end
        end else if (if_req) begin
          state_d         = BUSY_IF;
          req_d.write_op  = 1'b0;
          req_d.read_op   = 1'b1;
          req_d.addr      = if_addr;
          req_d.wdata     = '0;
          req_d.byte_mask = MASK_ALL;
          streak_d        = '0;
        end
      end
      BUSY_DM, BUSY_IF: begin
        // Only the ops drop; addr/wdata/mask keep their last values.
        if (mem_ack) begin
          state_d        = IDLE;
          req_d.read_op  = 1'b0;
          req_d.write_op = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (dm_rd_done_c) dm_rdata_d = mem_rdata;
    if (if_rd_done_c) if_rdata_d = mem_rdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      streak_q   <= '0;
      req_q      <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      streak_q   <= streak_d;
      req_q      <= req_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

  assign mem_read_op   = req_q.read_op;
  assign mem_write_op  = req_q.write_op;
  assign mem_addr      = req_q.addr;
  assign mem_wdata     = req_q.wdata;
  assign mem_byte_mask = req_q.byte_mask;

  // Stall drops and read data passes through in the owner's ack cycle.
  assign dm_stall = dm_pend & ~dm_ack_c;
  assign if_stall = if_req & ~if_ack_c;
  assign dm_rdata = dm_rd_done_c ? mem_rdata : dm_rdata_q;
  assign if_rdata = if_rd_done_c ? mem_rdata : if_rdata_q;

endmodule
